// File: rtl/dpa_pkg.sv
// rtl/dpa_pkg.sv - shared types and constants for the image-memory port arbiter
package dpa_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic RQ_PHOTO = 1'b0;
  localparam logic RQ_TIME  = 1'b1;

  localparam int IM_AW = 20;
  localparam int IM_DW = 24;

  function automatic arb_state_e own_state(input logic id);
    return (id == RQ_TIME) ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/im_arb_rtag.sv
// rtl/im_arb_rtag.sv - two-stage {valid, id} tag pipeline steering read returns to their issuer
module im_arb_rtag
  import dpa_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic issue_id,
  output logic rvalid0,
  output logic rvalid1
);

  logic s1_vld_q, s1_vld_d, s1_id_q, s1_id_d;
  logic s2_vld_q, s2_vld_d, s2_id_q, s2_id_d;

  always_comb begin
    s1_vld_d = issue;
    s1_id_d  = issue_id;
    s2_vld_d = s1_vld_q;
    s2_id_d  = s1_id_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_id_q  <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_id_q  <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_id_q  <= s1_id_d;
      s2_vld_q <= s2_vld_d;
      s2_id_q  <= s2_id_d;
    end
  end

  assign rvalid0 = s2_vld_q & (s2_id_q == RQ_PHOTO);
  assign rvalid1 = s2_vld_q & (s2_id_q == RQ_TIME);

endmodule

// File: rtl/im_port_arbiter.sv
// rtl/im_port_arbiter.sv - image-memory port arbiter: round-robin burst grants with burst-length preemption
// Define IM_ARB_STATS_EN to add the beats0/beats1/preempt_cnt/max_wait statistics outputs.
module im_port_arbiter
  import dpa_pkg::*;
#(
  parameter int AW        = IM_AW,
  parameter int DW        = IM_DW,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          last0,
  output logic          ack0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          last1,
  output logic          ack1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] im_a,
  output logic          im_wen_n,
  output logic [DW-1:0] im_d,
  input  logic [DW-1:0] im_q,
  output logic [1:0]    owner
`ifdef IM_ARB_STATS_EN
  ,
  output logic [31:0]   beats0,
  output logic [31:0]   beats1,
  output logic [15:0]   preempt_cnt,
  output logic [15:0]   max_wait
`endif
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d, cnt_inc;
  logic [AW-1:0] im_a_q, im_a_d;
  logic          im_wen_n_q, im_wen_n_d;
  logic [DW-1:0] im_d_q, im_d_d;

  logic          owning, own_id, beat_acc, other_req, preempt, release_now;
  logic          sel_we, sel_last;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    owning    = (state_q != ARB_IDLE);
    own_id    = (state_q == ARB_OWN1);
    ack0      = (state_q == ARB_OWN0) & req0;
    ack1      = (state_q == ARB_OWN1) & req1;
    beat_acc  = ack0 | ack1;
    sel_we    = own_id ? we1 : we0;
    sel_last  = own_id ? last1 : last0;
    sel_addr  = own_id ? addr1 : addr0;
    sel_wdata = own_id ? wdata1 : wdata0;
    other_req = own_id ? req0 : req1;

    // Saturating count: an owner past MAX_BURST with nobody waiting keeps going.
    cnt_inc     = (beat_acc && beat_cnt_q < MAX_B) ? beat_cnt_q + 8'd1 : beat_cnt_q;
    preempt     = owning & other_req & (cnt_inc >= MAX_B);
    release_now = owning & ((beat_acc & sel_last) | preempt);

    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = cnt_inc;
    if (!owning) begin
      if (req0 && req1) begin
        state_d = own_state(rr_ptr_q);
      end else if (req0) begin
        state_d = ARB_OWN0;
      end else if (req1) begin
        state_d = ARB_OWN1;
      end
    end else if (release_now) begin
      beat_cnt_d = 8'd0;
      rr_ptr_d   = ~own_id;
      state_d    = other_req ? own_state(~own_id) : ARB_IDLE;
    end

    im_a_d     = beat_acc ? sel_addr : im_a_q;
    im_wen_n_d = beat_acc ? ~sel_we : 1'b1;
    im_d_d     = beat_acc ? sel_wdata : im_d_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= 1'b0;
      beat_cnt_q <= 8'd0;
      im_a_q     <= '0;
      im_wen_n_q <= 1'b1;
      im_d_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      im_a_q     <= im_a_d;
      im_wen_n_q <= im_wen_n_d;
      im_d_q     <= im_d_d;
    end
  end

  assign im_a     = im_a_q;
  assign im_wen_n = im_wen_n_q;
  assign im_d     = im_d_q;
  assign owner    = state_q;
  assign rdata    = im_q;

  im_arb_rtag u_rtag (
    .clk      (clk),
    .reset    (reset),
    .issue    (beat_acc & ~sel_we),
    .issue_id (own_id),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1)
  );

`ifdef IM_ARB_STATS_EN
  logic [31:0] beats0_q, beats0_d, beats1_q, beats1_d;
  logic [15:0] preempt_cnt_q, preempt_cnt_d, max_wait_q, max_wait_d;
  logic [15:0] wait0_q, wait0_d, wait1_q, wait1_d;
  logic        preempt_evt;

  always_comb begin
    // A release that is not the owner's own last beat is a preemption.
    preempt_evt   = release_now & ~(beat_acc & sel_last);
    beats0_d      = beats0_q + {31'd0, ack0};
    beats1_d      = beats1_q + {31'd0, ack1};
    preempt_cnt_d = (preempt_evt && preempt_cnt_q != 16'hFFFF) ? preempt_cnt_q + 16'd1 : preempt_cnt_q;
    wait0_d       = (req0 & ~ack0) ? ((wait0_q == 16'hFFFF) ? wait0_q : wait0_q + 16'd1) : 16'd0;
    wait1_d       = (req1 & ~ack1) ? ((wait1_q == 16'hFFFF) ? wait1_q : wait1_q + 16'd1) : 16'd0;
    max_wait_d    = max_wait_q;
    if (wait0_d > max_wait_d) max_wait_d = wait0_d;
    if (wait1_d > max_wait_d) max_wait_d = wait1_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beats0_q      <= 32'd0;
      beats1_q      <= 32'd0;
      preempt_cnt_q <= 16'd0;
      max_wait_q    <= 16'd0;
      wait0_q       <= 16'd0;
      wait1_q       <= 16'd0;
    end else begin
      beats0_q      <= beats0_d;
      beats1_q      <= beats1_d;
      preempt_cnt_q <= preempt_cnt_d;
      max_wait_q    <= max_wait_d;
      wait0_q       <= wait0_d;
      wait1_q       <= wait1_d;
    end
  end

  assign beats0      = beats0_q;
  assign beats1      = beats1_q;
  assign preempt_cnt = preempt_cnt_q;
  assign max_wait    = max_wait_q;
`endif

endmodule

// File: tb/tb_im_port_arbiter.sv
// tb/tb_im_port_arbiter.sv - randomized bench for im_port_arbiter against a burst-level reference model
module tb_im_port_arbiter;

  localparam int AW   = 20;
  localparam int DW   = 24;
  localparam int MB   = 16;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, last0, ack0, rvalid0;
  logic          req1, we1, last1, ack1, rvalid1;
  logic [AW-1:0] addr0, addr1, im_a;
  logic [DW-1:0] wdata0, wdata1, rdata, im_d, im_q;
  logic          im_wen_n;
  logic [1:0]    owner;
`ifdef IM_ARB_STATS_EN
  logic [31:0]   beats0, beats1;
  logic [15:0]   preempt_cnt, max_wait;
`endif

  always #5 clk = ~clk;

  im_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .last0(last0), .ack0(ack0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .last1(last1), .ack1(ack1), .rvalid1(rvalid1),
    .rdata(rdata), .im_a(im_a), .im_wen_n(im_wen_n), .im_d(im_d), .im_q(im_q), .owner(owner)
`ifdef IM_ARB_STATS_EN
    , .beats0(beats0), .beats1(beats1), .preempt_cnt(preempt_cnt), .max_wait(max_wait)
`endif
  );

  // Memory environment: synchronous read, data one cycle after the address.
  logic [DW-1:0] env_mem [64];
  logic [DW-1:0] seed_mem [64];
  logic          load_mem;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 64; k++) env_mem[k] <= seed_mem[k];
    end else if (!im_wen_n) begin
      env_mem[im_a[5:0]] <= im_d;
    end
    im_q <= env_mem[im_a[5:0]];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;
  rd_t           rdq[$];
  logic [DW-1:0] ref_mem [64];
  int            cur, cnt, rr;
  logic [AW-1:0] exp_a;
  logic          exp_wen;
  logic [DW-1:0] exp_d;
  int            m_beats[2], m_pre, m_maxw, streak[2];

  // Stimulus state
  bit            active[2], acked[2];
  int            rem[2];
  logic [AW-1:0] nxa[2];
  bit            r[2], w[2], l[2];
  logic [DW-1:0] d[2];

  task automatic model_reset();
    cur = -1; cnt = 0; rr = 0;
    exp_a = '0; exp_wen = 1'b1; exp_d = '0;
    rdq.delete();
    m_beats[0] = 0; m_beats[1] = 0; m_pre = 0; m_maxw = 0; streak[0] = 0; streak[1] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (acked[i]) begin
        nxa[i] = nxa[i] + 1'b1;
        rem[i]--;
        if (rem[i] == 0) active[i] = 1'b0;
      end
      if (!active[i] && $urandom_range(0, 3) == 0) begin
        active[i] = 1'b1;
        rem[i]    = $urandom_range(1, 40);
        nxa[i]    = AW'($urandom);
      end
      r[i] = active[i] && ($urandom_range(0, 6) != 0);
      w[i] = 1'($urandom_range(0, 1));
      d[i] = DW'($urandom);
      l[i] = (rem[i] == 1);
    end
    req0 = r[0]; we0 = w[0]; addr0 = nxa[0]; wdata0 = d[0]; last0 = l[0];
    req1 = r[1]; we1 = w[1]; addr1 = nxa[1]; wdata1 = d[1]; last1 = l[1];
  endtask

  // Applies one cycle of the arbitration rules to the model.
  task automatic model_step(input int c, input bit e0, input bit e1);
    bit acc, lastv, wev, oreq;
    int o;
    logic [AW-1:0] av;
    logic [DW-1:0] dv;
    streak[0] = (req0 && !e0) ? streak[0] + 1 : 0;
    streak[1] = (req1 && !e1) ? streak[1] + 1 : 0;
    if (streak[0] > m_maxw) m_maxw = streak[0];
    if (streak[1] > m_maxw) m_maxw = streak[1];
    exp_wen = 1'b1;
    if (cur < 0) begin
      if (req0 && req1) cur = rr;
      else if (req0) cur = 0;
      else if (req1) cur = 1;
    end else begin
      o     = cur;
      acc   = (o == 0) ? e0 : e1;
      lastv = (o == 0) ? last0 : last1;
      wev   = (o == 0) ? we0 : we1;
      av    = (o == 0) ? addr0 : addr1;
      dv    = (o == 0) ? wdata0 : wdata1;
      oreq  = (o == 0) ? req1 : req0;
      if (acc) begin
        m_beats[o]++;
        if (cnt < MB) cnt++;
        exp_a = av; exp_wen = !wev; exp_d = dv;
        if (wev) ref_mem[av[5:0]] = dv;
        else rdq.push_back('{due: c + 2, id: o, data: ref_mem[av[5:0]]});
      end
      if ((acc && lastv) || (cnt >= MB && oreq)) begin
        if (!(acc && lastv)) m_pre++;
        cnt = 0;
        rr  = 1 - o;
        cur = oreq ? 1 - o : -1;
      end
    end
  endtask

  initial begin
    bit e0, e1, did_rst, rst_pending;
    reset = 1'b1; load_mem = 1'b1;
    for (int k = 0; k < 64; k++) begin
      seed_mem[k] = DW'($urandom);
      ref_mem[k]  = seed_mem[k];
    end
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; acked[i] = 1'b0; rem[i] = 0; nxa[i] = '0;
    end
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; last0 = 0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; last1 = 0;
    did_rst = 0; rst_pending = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_im_a", 32'(im_a), 0);
    check("rst_im_wen_n", 32'(im_wen_n), 1);
    check("rst_im_d", 32'(im_d), 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_rvalid", {rvalid1, rvalid0}, 0);
    check("rst_owner", 32'(owner), 0);
    load_mem = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      if (rst_pending) begin
        reset = 1'b0;
        rst_pending = 0;
      end
      drive();
      @(negedge clk);
      e0 = (cur == 0) && req0;
      e1 = (cur == 1) && req1;
      check("ack0", 32'(ack0), 32'(e0));
      check("ack1", 32'(ack1), 32'(e1));
      check("owner", 32'(owner), (cur < 0) ? 0 : cur + 1);
      check("im_a", 32'(im_a), 32'(exp_a));
      check("im_wen_n", 32'(im_wen_n), 32'(exp_wen));
      check("im_d", 32'(im_d), 32'(exp_d));
      if (rdq.size() > 0 && rdq[0].due == c) begin
        check("rvalid0", 32'(rvalid0), (rdq[0].id == 0) ? 1 : 0);
        check("rvalid1", 32'(rvalid1), (rdq[0].id == 1) ? 1 : 0);
        check("rdata", 32'(rdata), 32'(rdq[0].data));
        void'(rdq.pop_front());
      end else begin
        check("rvalid_idle", {rvalid1, rvalid0}, 0);
      end
      acked[0] = ack0;
      acked[1] = ack1;
      if (!did_rst && c > 1500 && cur == 1 && cnt >= 2) begin
        did_rst = 1;
        #2 reset = 1'b1;
        #1;
        check("midrst_im_wen_n", 32'(im_wen_n), 1);
        check("midrst_ack", {ack1, ack0}, 0);
        check("midrst_owner", 32'(owner), 0);
        check("midrst_rvalid", {rvalid1, rvalid0}, 0);
        acked[0] = 1'b0;
        acked[1] = 1'b0;
        model_reset();
        rst_pending = 1;
      end else begin
        model_step(c, e0, e1);
      end
      @(posedge clk); #1;
    end

`ifdef IM_ARB_STATS_EN
    check("beats0", beats0, 32'(m_beats[0]));
    check("beats1", beats1, 32'(m_beats[1]));
    check("preempt_cnt", 32'(preempt_cnt), 32'(m_pre));
    check("max_wait", 32'(max_wait), 32'(m_maxw));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
